// File: rtl/reg_op_arbiter_pkg.sv
// Shared definitions for the round-robin op-register arbiter: FSM state
// encoding, datapath control bit positions and command op bit positions.
package reg_op_arbiter_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 2;
    localparam int CTRL_W = 3;

    // Command op bits supplied by each requester.
    localparam int OP_DBL = 0;
    localparam int OP_INC = 1;

    // Datapath control bits.
    localparam int DP_EN  = 0;
    localparam int DP_DBL = 1;
    localparam int DP_INC = 2;

    // Code 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/reg_op_arbiter_if.sv
// Requester and response channels of the op-register arbiter. The master
// side is the requester/consumer, the slave side is the arbiter.
interface reg_op_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_data;
    logic [2*NUM_REQ-1:0] req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [3:0]           rsp_data;

    modport master (
        output req_valid, req_data, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/reg_op_arbiter_rr_arbiter.sv
// Round-robin selector: picks the first asserted request starting at the
// pointer position and wrapping modulo NUM_REQ.
module reg_op_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               any_o
);

    // Search ptr, ptr+1, ... and stop at the first asserted request.
    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!any_o && req_i[(int'(ptr_i) + off) % NUM_REQ]) begin
                any_o                                     = 1'b1;
                grant_o[(int'(ptr_i) + off) % NUM_REQ]    = 1'b1;
                grant_idx_o = ID_W'((int'(ptr_i) + off) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/reg_op_arbiter.sv
// Round-robin scheduler sharing one 4-bit op-register datapath among
// NUM_REQ requesters: accept one command, drive the datapath for one cycle,
// then hold the result with the owner's ID until the consumer takes it.
module reg_op_arbiter
    import reg_op_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    reg_op_arbiter_if.slave        bus,
    output logic [DATA_W-1:0]      dp_data_in,
    output logic [CTRL_W-1:0]      dp_control,
    input  logic [DATA_W-1:0]      dp_data_out,
    output logic                   busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t              state_q;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q;
    logic [CTRL_W-1:0]   dp_control_q;
    logic [DATA_W-1:0]   dp_data_in_q;
    logic                rsp_valid_q;
    logic                busy_q;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic [DATA_W-1:0]   sel_data;
    logic [OP_W-1:0]     sel_op;

    reg_op_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i       (bus.req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    // Operand/op of the granted requester and the pointer slot after it.
    always_comb begin
        sel_data = bus.req_data[DATA_W*int'(grant_idx) +: DATA_W];
        sel_op   = bus.req_op[OP_W*int'(grant_idx) +: OP_W];
        ptr_d    = grant_idx + ID_W'(1);
        if (int'(grant_idx) == NUM_REQ - 1) begin
            ptr_d = '0;
        end
    end

    // Command FSM: capture on the IDLE handshake, one ISSUE cycle, hold RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            dp_control_q <= '0;
            dp_data_in_q <= '0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        id_q                 <= grant_idx;
                        ptr_q                <= ptr_d;
                        dp_data_in_q         <= sel_data;
                        dp_control_q[DP_INC] <= sel_op[OP_INC];
                        dp_control_q[DP_DBL] <= sel_op[OP_DBL];
                        dp_control_q[DP_EN]  <= 1'b1;
                        busy_q               <= 1'b1;
                        state_q              <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    dp_control_q <= '0;
                    dp_data_in_q <= '0;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    dp_control_q <= '0;
                    dp_data_in_q <= '0;
                    rsp_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    // Accept is offered only in IDLE and is forced low while reset is held.
    assign bus.req_ready = (state_q == ST_IDLE && rst_n) ? grant : '0;

    // The datapath holds its register outside ISSUE, so the result is read live.
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = rsp_valid_q ? dp_data_out : '0;
    assign dp_control    = dp_control_q;
    assign dp_data_in    = dp_data_in_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_reg_op_arbiter.sv
// Randomized self-checking bench for reg_op_arbiter with a datapath model
// and a behavioural arbitration/result model.
module tb_reg_op_arbiter;

    localparam int N   = 2;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     dp_data_in;
    logic [2:0]     dp_control;
    logic [3:0]     dp_data_out;
    logic           busy;
    logic [3:0]     dp_q = 4'h0;

    int             checks = 0;
    int             errors = 0;
    int             ptr_m  = 0;
    bit             rvalid [N];
    logic [3:0]     rdata  [N];
    logic [1:0]     rop    [N];

    reg_op_arbiter_if #(.NUM_REQ(N)) bus ();

    reg_op_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dp_data_in  (dp_data_in),
        .dp_control  (dp_control),
        .dp_data_out (dp_data_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Datapath register: load operand, optionally double, then optionally increment.
    function automatic logic [3:0] dp_next(input logic [3:0] d, input logic [2:0] c);
        int v;
        v = int'(d);
        if (c[1]) v = v * 2;
        if (c[2]) v = v + 1;
        return 4'(v % 16);
    endfunction

    always @(posedge clk) begin
        if (dp_control[0]) dp_q <= dp_next(dp_data_in, dp_control);
    end
    assign dp_data_out = dp_q;

    // Expected result of a command: op bit0 doubles, op bit1 then adds one, mod 16.
    function automatic int exp_result(input int d, input int op);
        int r;
        r = d;
        if (op % 2 == 1) r = r * 2;
        if (op / 2 == 1) r = r + 1;
        return r % 16;
    endfunction

    // Round-robin reference: first valid requester at or after p.
    function automatic int pick(input int p);
        for (int off = 0; off < N; off++) begin
            if (rvalid[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    task automatic apply_reqs();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]       = rvalid[i];
            bus.req_data[4*i +: 4] = rdata[i];
            bus.req_op[2*i +: 2]   = rop[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [IDW+4:0] rsp_now;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            rvalid[i] = 1'b1;
            rdata[i]  = 4'($urandom);
            rop[i]    = 2'($urandom);
        end
        apply_reqs();
        bus.rsp_ready = 1'b1;
        step();
        step();
        rsp_now = {bus.rsp_valid, bus.rsp_id, bus.rsp_data};
        checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
        checks++; if (dp_control !== 3'b000) begin errors++; $display("FAIL reset_dp_control: got %b expected 000", dp_control); end
        checks++; if (dp_data_in !== 4'h0) begin errors++; $display("FAIL reset_dp_data_in: got %h expected 0", dp_data_in); end
        checks++; if (rsp_now !== '0) begin errors++; $display("FAIL reset_rsp: got %h expected 0", rsp_now); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        for (int i = 0; i < N; i++) rvalid[i] = 1'b0;
        apply_reqs();
        bus.rsp_ready = 1'b0;
        rst_n = 1'b1;
        ptr_m = 0;
        step();
    endtask

    // One transaction from a lone requester, with an optional response stall.
    task automatic single_txn(input int id, input logic [3:0] d, input logic [1:0] op, input int stall);
        logic [N-1:0]   oh;
        logic [IDW+4:0] exp_rsp, got_rsp;
        oh = '0;
        oh[id] = 1'b1;
        for (int i = 0; i < N; i++) begin
            rvalid[i] = (i == id);
            rdata[i]  = (i == id) ? d : 4'($urandom);
            rop[i]    = (i == id) ? op : 2'($urandom);
        end
        apply_reqs();
        bus.rsp_ready = 1'($urandom);
        #1;
        checks++; if (bus.req_ready !== oh) begin errors++; $display("FAIL idle_ready id=%0d: got %b expected %b", id, bus.req_ready, oh); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
        step();
        ptr_m = (id + 1) % N;
        rvalid[id] = 1'b0;
        rdata[id]  = 4'($urandom);
        rop[id]    = 2'($urandom);
        apply_reqs();
        bus.rsp_ready = 1'($urandom);
        checks++; if (dp_control !== {op, 1'b1}) begin errors++; $display("FAIL issue_ctrl: got %b expected %b", dp_control, {op, 1'b1}); end
        checks++; if (dp_data_in !== d) begin errors++; $display("FAIL issue_data: got %h expected %h", dp_data_in, d); end
        checks++; if ({bus.rsp_valid, busy, bus.req_ready} !== {2'b01, {N{1'b0}}}) begin errors++; $display("FAIL issue_flags: got valid=%b busy=%b ready=%b expected 0/1/0", bus.rsp_valid, busy, bus.req_ready); end
        step();
        exp_rsp = {1'b1, IDW'(id), 4'(exp_result(int'(d), int'(op)))};
        got_rsp = {bus.rsp_valid, bus.rsp_id, bus.rsp_data};
        checks++; if (got_rsp !== exp_rsp) begin errors++; $display("FAIL resp id=%0d d=%h op=%b: got %h expected %h", id, d, op, got_rsp, exp_rsp); end
        checks++; if ({dp_control, dp_data_in, busy} !== 8'h01) begin errors++; $display("FAIL resp_dp: got ctrl=%b data=%h busy=%b expected 000/0/1", dp_control, dp_data_in, busy); end
        for (int s = 0; s < stall; s++) begin
            for (int i = 0; i < N; i++) rvalid[i] = 1'($urandom);
            rvalid[s % N] = 1'b1;
            apply_reqs();
            bus.rsp_ready = 1'b0;
            #1;
            got_rsp = {bus.rsp_valid, bus.rsp_id, bus.rsp_data};
            checks++; if (got_rsp !== exp_rsp) begin errors++; $display("FAIL stall_rsp cycle=%0d: got %h expected %h", s, got_rsp, exp_rsp); end
            checks++; if ({bus.req_ready, dp_control} !== '0) begin errors++; $display("FAIL stall_ready_ctrl cycle=%0d: got ready=%b ctrl=%b expected 0", s, bus.req_ready, dp_control); end
            step();
        end
        for (int i = 0; i < N; i++) rvalid[i] = 1'b0;
        apply_reqs();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        checks++; if ({bus.rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL done_idle: got valid=%b busy=%b expected 0/0", bus.rsp_valid, busy); end
    endtask

    task automatic test_basic();
        single_txn(0, 4'h5, 2'b00, 0);
        single_txn(1, 4'h9, 2'b11, 0);
        single_txn(1, 4'hF, 2'b10, 0);
        single_txn(0, 4'hA, 2'b01, 0);
    endtask

    task automatic test_stall();
        single_txn(int'($urandom_range(N - 1, 0)), 4'($urandom), 2'($urandom), 5);
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            single_txn(int'($urandom_range(N - 1, 0)), 4'($urandom), 2'($urandom), int'($urandom_range(3, 0)));
        end
    endtask

    // Continuous traffic with rsp_ready high; held valids must be served in round-robin order.
    task automatic run_arb(input bit all_valid, input int n);
        int             g;
        logic [N-1:0]   oh;
        logic [3:0]     ed;
        logic [1:0]     eop;
        logic [IDW+4:0] exp_rsp, got_rsp;
        bus.rsp_ready = 1'b1;
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!rvalid[i] && (all_valid || $urandom_range(1, 0) == 1)) begin
                    rvalid[i] = 1'b1;
                    rdata[i]  = 4'($urandom);
                    rop[i]    = 2'($urandom);
                end
            end
            if (pick(0) < 0) begin
                g = int'($urandom_range(N - 1, 0));
                rvalid[g] = 1'b1;
                rdata[g]  = 4'($urandom);
                rop[g]    = 2'($urandom);
            end
            apply_reqs();
            #1;
            g = pick(ptr_m);
            oh = '0;
            oh[g] = 1'b1;
            checks++; if (bus.req_ready !== oh) begin errors++; $display("FAIL rr_grant txn=%0d: got %b expected %b", t, bus.req_ready, oh); end
            checks++; if ({busy, bus.rsp_valid} !== 2'b00) begin errors++; $display("FAIL rr_idle txn=%0d: got busy=%b valid=%b expected 0/0", t, busy, bus.rsp_valid); end
            ed  = rdata[g];
            eop = rop[g];
            step();
            ptr_m = (g + 1) % N;
            rvalid[g] = all_valid ? 1'b1 : 1'($urandom);
            rdata[g]  = 4'($urandom);
            rop[g]    = 2'($urandom);
            apply_reqs();
            #1;
            checks++; if ({dp_control, dp_data_in} !== {eop, 1'b1, ed}) begin errors++; $display("FAIL rr_issue txn=%0d: got %b_%h expected %b_%h", t, dp_control, dp_data_in, {eop, 1'b1}, ed); end
            checks++; if ({busy, bus.req_ready} !== {1'b1, {N{1'b0}}}) begin errors++; $display("FAIL rr_issue_flags txn=%0d: got busy=%b ready=%b expected 1/0", t, busy, bus.req_ready); end
            step();
            exp_rsp = {1'b1, IDW'(g), 4'(exp_result(int'(ed), int'(eop)))};
            got_rsp = {bus.rsp_valid, bus.rsp_id, bus.rsp_data};
            checks++; if (got_rsp !== exp_rsp) begin errors++; $display("FAIL rr_resp txn=%0d: got %h expected %h", t, got_rsp, exp_rsp); end
            checks++; if ({busy, bus.req_ready} !== {1'b1, {N{1'b0}}}) begin errors++; $display("FAIL rr_resp_flags txn=%0d: got busy=%b ready=%b expected 1/0", t, busy, bus.req_ready); end
            step();
        end
        for (int i = 0; i < N; i++) rvalid[i] = 1'b0;
        apply_reqs();
        bus.rsp_ready = 1'b0;
        #1;
        checks++; if ({busy, bus.rsp_valid} !== 2'b00) begin errors++; $display("FAIL rr_end_idle: got busy=%b valid=%b expected 0/0", busy, bus.rsp_valid); end
    endtask

    task automatic test_fairness();
        run_arb(1'b1, 8);
    endtask

    task automatic test_back_to_back();
        run_arb(1'b0, 30);
    endtask

    // Reset asserted during ISSUE: outputs clear at once, no response, pointer back to 0.
    task automatic test_reset_mid();
        logic [3:0]     dp_before;
        logic [IDW+4:0] got_rsp;
        single_txn(0, 4'h3, 2'b00, 0);
        rvalid[0] = 1'b1;
        rdata[0]  = 4'h7;
        rop[0]    = 2'b11;
        apply_reqs();
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL mid_grant: got %b expected 01", bus.req_ready); end
        step();
        dp_before = dp_q;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        got_rsp = {bus.rsp_valid, bus.rsp_id, bus.rsp_data};
        checks++; if ({dp_control, dp_data_in, busy, bus.req_ready} !== '0) begin errors++; $display("FAIL mid_reset_outs: got ctrl=%b data=%h busy=%b ready=%b expected 0", dp_control, dp_data_in, busy, bus.req_ready); end
        checks++; if (got_rsp !== '0) begin errors++; $display("FAIL mid_reset_rsp: got %h expected 0", got_rsp); end
        step();
        step();
        checks++; if (dp_q !== dp_before) begin errors++; $display("FAIL mid_reset_dp_hold: got %h expected %h", dp_q, dp_before); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_no_rsp: got %b expected 0", bus.rsp_valid); end
        rvalid[0] = 1'b0;
        rvalid[1] = 1'b1;
        apply_reqs();
        rst_n = 1'b1;
        ptr_m = 0;
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL post_reset_req1: got %b expected 10", bus.req_ready); end
        rvalid[0] = 1'b1;
        apply_reqs();
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL post_reset_ptr0: got %b expected 01", bus.req_ready); end
        rvalid[0] = 1'b0;
        rvalid[1] = 1'b0;
        apply_reqs();
        bus.rsp_ready = 1'b0;
        step();
        step();
        checks++; if ({busy, bus.rsp_valid} !== 2'b00) begin errors++; $display("FAIL post_reset_idle: got busy=%b valid=%b expected 0/0", busy, bus.rsp_valid); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rvalid[i] = 1'b0;
            rdata[i]  = 4'h0;
            rop[i]    = 2'b00;
        end
        apply_reqs();
        bus.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_fairness();
        test_back_to_back();
        test_reset_mid();
        single_txn(1, 4'h6, 2'b01, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
